// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register with a one-entry skid buffer so in_ready is registered.
// Optional stall/flush statistics counters are enabled by defining IFID_STAT_EN.
module ifid_skid_reg #(
  parameter int PC_W    = 64,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr
`ifdef IFID_STAT_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PC_W-1:0]    main_pc, main_pc_nxt, skid_pc, skid_pc_nxt;
  logic [INSTR_W-1:0] main_instr, main_instr_nxt, skid_instr, skid_instr_nxt;
  logic               in_acc, out_acc;

  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign out_pc    = main_pc;
  assign out_instr = main_instr;

  // Next-state and storage update; main is zeroed whenever the stage empties so ID sees a bubble.
  always_comb begin
    state_nxt      = state;
    main_pc_nxt    = main_pc;
    main_instr_nxt = main_instr;
    skid_pc_nxt    = skid_pc;
    skid_instr_nxt = skid_instr;
    if (flush) begin
      state_nxt      = ST_EMPTY;
      main_pc_nxt    = {PC_W{1'b0}};
      main_instr_nxt = {INSTR_W{1'b0}};
      skid_pc_nxt    = {PC_W{1'b0}};
      skid_instr_nxt = {INSTR_W{1'b0}};
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_acc) begin
            state_nxt      = ST_FULL;
            main_pc_nxt    = in_pc;
            main_instr_nxt = in_instr;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (in_acc && out_acc) begin
            main_pc_nxt    = in_pc;
            main_instr_nxt = in_instr;
          end else if (in_acc) begin
            state_nxt      = ST_SKID;
            skid_pc_nxt    = in_pc;
            skid_instr_nxt = in_instr;
          end else if (out_acc) begin
            state_nxt      = ST_EMPTY;
            main_pc_nxt    = {PC_W{1'b0}};
            main_instr_nxt = {INSTR_W{1'b0}};
          end else begin
            state_nxt = ST_FULL;
          end
        end
        ST_SKID: begin
          if (out_acc) begin
            state_nxt      = ST_FULL;
            main_pc_nxt    = skid_pc;
            main_instr_nxt = skid_instr;
            skid_pc_nxt    = {PC_W{1'b0}};
            skid_instr_nxt = {INSTR_W{1'b0}};
          end else begin
            state_nxt = ST_SKID;
          end
        end
        default: begin
          state_nxt      = ST_EMPTY;
          main_pc_nxt    = {PC_W{1'b0}};
          main_instr_nxt = {INSTR_W{1'b0}};
          skid_pc_nxt    = {PC_W{1'b0}};
          skid_instr_nxt = {INSTR_W{1'b0}};
        end
      endcase
    end
  end

  // State, storage and handshake flags; flags are derived from the next state so they stay registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      main_pc    <= {PC_W{1'b0}};
      main_instr <= {INSTR_W{1'b0}};
      skid_pc    <= {PC_W{1'b0}};
      skid_instr <= {INSTR_W{1'b0}};
      out_valid  <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_nxt;
      main_pc    <= main_pc_nxt;
      main_instr <= main_instr_nxt;
      skid_pc    <= skid_pc_nxt;
      skid_instr <= skid_instr_nxt;
      out_valid  <= (state_nxt != ST_EMPTY);
      in_ready   <= (state_nxt != ST_SKID);
    end
  end

`ifdef IFID_STAT_EN
  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (flush && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end
`endif

endmodule

// File: doc/ifid_skid_reg.md
IFID_SKID_REG -- requirements
Module: ifid_skid_reg

Interface
REQ-001 SHALL have parameter PC_W, default 64, meaning the PC field width in bits.
REQ-002 SHALL have parameter INSTR_W, default 32, meaning the instruction field width in bits.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the statistics counter width in bits.
REQ-004 clk  in  1  the only clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 flush  in  1  discard all held entries.
REQ-007 in_valid  in  1  upstream (IF) entry present.
REQ-008 in_ready  out  1  stage can accept an entry; registered, not combinational from out_ready.
REQ-009 in_pc  in  PC_W  fetched PC.
REQ-010 in_instr  in  INSTR_W  fetched instruction.
REQ-011 out_valid  out  1  entry presented to ID.
REQ-012 out_ready  in  1  ID accepts; low means stall.
REQ-013 out_pc  out  PC_W  held PC.
REQ-014 out_instr  out  INSTR_W  held instruction.
REQ-015 stall_cnt  out  CNT_W  stall-cycle count (only with IFID_STAT_EN).
REQ-016 flush_cnt  out  CNT_W  flush count (only with IFID_STAT_EN).

Function
REQ-017 Transfers: in-accept = in_valid && in_ready; out-accept = out_valid && out_ready.
REQ-018 Storage SHALL be a main register plus one skid register; the FSM has states EMPTY (none held), FULL (main only), SKID (main and skid).
REQ-019 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID.
REQ-020 out_valid SHALL be 1 in FULL and SKID; out_pc/out_instr SHALL always show the main register.
REQ-021 EMPTY: an in-accept loads main and moves to FULL; otherwise stay.
REQ-022 FULL with in-accept and out-accept: load main with new entry, stay FULL (one transfer per cycle, latency 1).
REQ-023 FULL with in-accept and no out-accept: write entry to skid, go to SKID.
REQ-024 FULL with out-accept and no in-accept: go to EMPTY.
REQ-025 SKID with out-accept: copy skid to main, go to FULL; without it, hold both.
REQ-026 Entry order SHALL be preserved; no entry is dropped or duplicated absent flush.
REQ-027 flush SHALL, next edge, go to EMPTY and zero main and skid, regardless of state, in_valid or out_ready; an entry offered in the flush cycle is discarded.
REQ-028 In EMPTY, out_pc and out_instr SHALL read 0 (bubble = all-zero instruction).

Reset
REQ-029 When reset_n is 0 at an edge: state EMPTY, main/skid zero, out_valid 0, in_ready 1, counters 0.
REQ-030 Reset SHALL override flush and any in-flight transfer.

Configuration
REQ-031 Macro IFID_STAT_EN defined: stall_cnt increments each cycle with out_valid && !out_ready.
REQ-032 Macro IFID_STAT_EN defined: flush_cnt increments each cycle flush is 1 (not during reset).
REQ-033 Both counters SHALL saturate at 2^CNT_W-1.
REQ-034 Macro IFID_STAT_EN undefined: stall_cnt and flush_cnt ports and their logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Reset: hold reset_n=0 for 2 cycles -> out_valid=0, in_ready=1, out_pc=0, out_instr=0.
REQ-036 Streaming: out_ready=1; send PC 0x0,0x4,0x8 with instr 0x00500093,0x00A00113,0x002081B3 back-to-back -> same order at output, each 1 cycle after accept, in_ready stays 1.
REQ-037 Stall: out_ready=0 while sending PC 0x10 then 0x14 -> in_ready=0 after 2nd accept, output holds 0x10; raise out_ready -> 0x10 then 0x14, nothing lost.
REQ-038 Flush in SKID: flush=1 with in_valid=1 PC 0x18 -> next cycle out_valid=0, out_pc=0, in_ready=1; 0x18 never appears.
REQ-039 Reset mid-SKID with flush=1 -> EMPTY, all outputs 0, flush_cnt=0.
REQ-040 IFID_STAT_EN with CNT_W=4: hold stall 20 cycles -> stall_cnt=15; 3 flush cycles -> flush_cnt=3.
